// File: rtl/bcd_time_loader.sv
// Collects six BCD digits (HH MM SS) through a valid/ready handshake, validates
// each one, and emits the binary time with a one-cycle load strobe.
module bcd_time_loader #(
  parameter int unsigned TIMEOUT_CYCLES = 100000000
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [3:0] digit_in,
  input  logic       digit_valid,
  input  logic       cancel,
  output logic       digit_ready,
  output logic [2:0] digit_idx,
  output logic       busy,
  output logic [5:0] set_hr,
  output logic [5:0] set_min,
  output logic [5:0] set_sec,
  output logic       set_load,
  output logic       entry_err
);

  localparam int unsigned CW = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
  localparam logic [CW-1:0] CNT_LAST = CW'(TIMEOUT_CYCLES - 1);

  typedef enum logic [2:0] {
    IDLE,
    COLLECT,
    CONVERT,
    LOAD,
    ERROR
  } state_e;

  state_e        state_q, state_d;
  logic [2:0]    idx_q, idx_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [3:0]    dig_q [6];
  logic [3:0]    dig_d [6];
  logic [5:0]    hr_q, min_q, sec_q;
  logic [5:0]    hr_bin, min_bin, sec_bin;
  logic          hs;
  logic          digit_ok;

  assign digit_ready = (state_q == IDLE) || (state_q == COLLECT);
  assign busy        = (state_q != IDLE);
  assign set_load    = (state_q == LOAD);
  assign entry_err   = (state_q == ERROR);
  assign digit_idx   = idx_q;
  assign set_hr      = hr_q;
  assign set_min     = min_q;
  assign set_sec     = sec_q;
  assign hs          = digit_valid && digit_ready;

  // Limit for the current position; hour-ones depends on the stored hour-tens.
  always_comb begin
    digit_ok = 1'b0;
    case (idx_q)
      3'd0:        digit_ok = (digit_in <= 4'd2);
      3'd1:        digit_ok = (dig_q[0] == 4'd2) ? (digit_in <= 4'd3) : (digit_in <= 4'd9);
      3'd2, 3'd4:  digit_ok = (digit_in <= 4'd5);
      default:     digit_ok = (digit_in <= 4'd9);
    endcase
  end

  always_comb begin
    hr_bin  = 6'(dig_q[0]) * 6'd10 + 6'(dig_q[1]);
    min_bin = 6'(dig_q[2]) * 6'd10 + 6'(dig_q[3]);
    sec_bin = 6'(dig_q[4]) * 6'd10 + 6'(dig_q[5]);
  end

  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    cnt_d   = cnt_q;
    dig_d   = dig_q;
    case (state_q)
      IDLE, COLLECT: begin
        if (cancel) begin
          state_d = IDLE;
        end else if (hs) begin
          if (digit_ok) begin
            dig_d[idx_q] = digit_in;
            idx_d        = idx_q + 3'd1;
            cnt_d        = '0;
            state_d      = (idx_q == 3'd5) ? CONVERT : COLLECT;
          end else begin
            state_d = ERROR;
          end
        end else if (state_q == COLLECT) begin
          if (cnt_q == CNT_LAST) begin
            state_d = ERROR;
          end else begin
            cnt_d = cnt_q + CW'(1);
          end
        end
      end
      CONVERT: state_d = LOAD;
      LOAD:    state_d = IDLE;
      ERROR:   state_d = IDLE;
      default: state_d = IDLE;
    endcase
    if (state_d == ERROR) begin
      cnt_d = '0;
    end
    // Every return to IDLE (cancel, error, load done) drops the entry.
    if (state_d == IDLE) begin
      idx_d = '0;
      cnt_d = '0;
      dig_d = '{default: '0};
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      idx_q   <= '0;
      cnt_q   <= '0;
      dig_q   <= '{default: '0};
      hr_q    <= '0;
      min_q   <= '0;
      sec_q   <= '0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      cnt_q   <= cnt_d;
      dig_q   <= dig_d;
      if (state_q == CONVERT) begin
        hr_q  <= hr_bin;
        min_q <= min_bin;
        sec_q <= sec_bin;
      end
    end
  end

endmodule

// File: tb/tb_bcd_time_loader.sv
// Directed bench for bcd_time_loader: drives and samples on the falling edge,
// with hand-computed expectations checked by immediate assertions.
module tb_bcd_time_loader;

  logic       clk;
  logic       rst_n;
  logic [3:0] digit_in;
  logic       digit_valid;
  logic       cancel;
  logic       digit_ready;
  logic [2:0] digit_idx;
  logic       busy;
  logic [5:0] set_hr;
  logic [5:0] set_min;
  logic [5:0] set_sec;
  logic       set_load;
  logic       entry_err;

  int passed = 0;
  int total  = 0;

  bcd_time_loader #(.TIMEOUT_CYCLES(16)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .digit_in    (digit_in),
    .digit_valid (digit_valid),
    .cancel      (cancel),
    .digit_ready (digit_ready),
    .digit_idx   (digit_idx),
    .busy        (busy),
    .set_hr      (set_hr),
    .set_min     (set_min),
    .set_sec     (set_sec),
    .set_load    (set_load),
    .entry_err   (entry_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) begin
      passed++;
    end else begin
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic put(input logic [3:0] d, input logic c);
    @(negedge clk);
    digit_in    = d;
    digit_valid = 1'b1;
    cancel      = c;
  endtask

  task automatic idle();
    @(negedge clk);
    digit_in    = 4'd0;
    digit_valid = 1'b0;
    cancel      = 1'b0;
  endtask

  initial begin
    logic [3:0] seq1 [6];
    logic [3:0] seq2 [6];
    logic       strobe_seen;
    seq1 = '{4'd2, 4'd3, 4'd5, 4'd9, 4'd5, 4'd9};
    seq2 = '{4'd0, 4'd0, 4'd0, 4'd0, 4'd0, 4'd1};
    rst_n       = 1'b0;
    digit_in    = 4'd0;
    digit_valid = 1'b0;
    cancel      = 1'b0;
    #12;
    check("rst_ready", digit_ready, 1);
    check("rst_idx",   digit_idx,   0);
    check("rst_busy",  busy,        0);
    check("rst_hr",    set_hr,      0);
    check("rst_load",  set_load,    0);
    check("rst_err",   entry_err,   0);
    @(negedge clk);
    rst_n = 1'b1;

    // 23:59:59 back-to-back
    for (int i = 0; i < 6; i++) begin
      put(seq1[i], 1'b0);
      if (i > 0) check("t1_idx", digit_idx, i);
    end
    idle();
    check("t1_conv_load", set_load,    0);
    check("t1_conv_idx",  digit_idx,   6);
    check("t1_conv_rdy",  digit_ready, 0);
    check("t1_conv_busy", busy,        1);
    idle();
    check("t1_load",     set_load,  1);
    check("t1_hr",       set_hr,    23);
    check("t1_min",      set_min,   59);
    check("t1_sec",      set_sec,   59);
    check("t1_load_err", entry_err, 0);
    idle();
    check("t1_done_load", set_load,  0);
    check("t1_done_idx",  digit_idx, 0);
    check("t1_done_busy", busy,      0);
    check("t1_hold_hr",   set_hr,    23);

    // 2,4 rejected at hour-ones
    put(4'd2, 1'b0);
    put(4'd4, 1'b0);
    check("t2_idx1", digit_idx, 1);
    idle();
    check("t2_err",  entry_err,   1);
    check("t2_rdy",  digit_ready, 0);
    check("t2_load", set_load,    0);
    idle();
    check("t2_err_end", entry_err, 0);
    check("t2_idx",     digit_idx, 0);
    check("t2_hr",      set_hr,    23);
    check("t2_min",     set_min,   59);
    check("t2_sec",     set_sec,   59);

    // timeout after 16 idle cycles in COLLECT
    put(4'd1, 1'b0);
    put(4'd2, 1'b0);
    put(4'd3, 1'b0);
    idle();
    check("t3_idx", digit_idx, 3);
    strobe_seen = entry_err | set_load;
    for (int i = 0; i < 15; i++) begin
      @(negedge clk);
      strobe_seen = strobe_seen | entry_err | set_load;
    end
    check("t3_no_early_strobe", strobe_seen, 0);
    @(negedge clk);
    check("t3_err",  entry_err, 1);
    check("t3_load", set_load,  0);
    @(negedge clk);
    check("t3_idx_clr", digit_idx, 0);
    check("t3_idle",    busy,      0);

    // cancel together with a digit, then 00:00:01
    put(4'd0, 1'b0);
    put(4'd7, 1'b0);
    put(4'd3, 1'b1);
    check("t4_idx2", digit_idx, 2);
    idle();
    check("t4_idx",  digit_idx, 0);
    check("t4_busy", busy,      0);
    check("t4_err",  entry_err, 0);
    check("t4_load", set_load,  0);
    idle();
    check("t4_quiet", entry_err | set_load, 0);
    for (int i = 0; i < 6; i++) put(seq2[i], 1'b0);
    @(negedge clk);
    digit_valid = 1'b0;
    cancel      = 1'b1;
    check("t4_conv_busy", busy, 1);
    @(negedge clk);
    check("t4_load2", set_load, 1);
    check("t4_hr2",   set_hr,   0);
    check("t4_min2",  set_min,  0);
    check("t4_sec2",  set_sec,  1);
    idle();
    check("t4_idx_end", digit_idx, 0);

    // asynchronous reset mid-entry
    put(4'd1, 1'b0);
    put(4'd2, 1'b0);
    put(4'd3, 1'b0);
    put(4'd4, 1'b0);
    idle();
    check("t5_idx4", digit_idx, 4);
    #2 rst_n = 1'b0;
    #1;
    check("t5_idx",   digit_idx,   0);
    check("t5_busy",  busy,        0);
    check("t5_rdy",   digit_ready, 1);
    check("t5_sec",   set_sec,     0);
    check("t5_strb",  set_load | entry_err, 0);
    @(negedge clk);
    rst_n = 1'b1;
    strobe_seen = 1'b0;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      strobe_seen = strobe_seen | entry_err | set_load;
    end
    check("t5_no_strobe", strobe_seen, 0);
    check("t5_idx_after", digit_idx,   0);

    // out-of-range first digit
    put(4'd10, 1'b0);
    idle();
    check("t6_err", entry_err,   1);
    check("t6_rdy", digit_ready, 0);
    idle();
    check("t6_err_end", entry_err,   0);
    check("t6_rdy_end", digit_ready, 1);
    check("t6_idx",     digit_idx,   0);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule

// File: doc/bcd_time_loader.md
BCD_TIME_LOADER -- requirements
Module: bcd_time_loader

Interface
REQ-001 SHALL provide parameter TIMEOUT_CYCLES, default 100000000, max clk cycles allowed between accepted digits (2 s at 50 MHz).
REQ-002 SHALL provide port clk  input  1  single system clock; all logic on rising edge.
REQ-003 SHALL provide port rst_n  input  1  asynchronous active-low reset.
REQ-004 SHALL provide port digit_in  input  4  BCD digit, sampled when digit_valid and digit_ready are both high.
REQ-005 SHALL provide port digit_valid  input  1  source offers digit_in this cycle.
REQ-006 SHALL provide port cancel  input  1  abort the current entry.
REQ-007 SHALL provide port digit_ready  output  1  block can accept a digit this cycle.
REQ-008 SHALL provide port digit_idx  output  3  number of digits accepted in the current entry (0..6).
REQ-009 SHALL provide port busy  output  1  entry in progress (any state other than IDLE).
REQ-010 SHALL provide port set_hr  output  6  binary hours 0..23.
REQ-011 SHALL provide port set_min  output  6  binary minutes 0..59.
REQ-012 SHALL provide port set_sec  output  6  binary seconds 0..59.
REQ-013 SHALL provide port set_load  output  1  one-cycle strobe; set_hr, set_min and set_sec are valid.
REQ-014 SHALL provide port entry_err  output  1  one-cycle strobe; entry rejected.

Function
REQ-015 SHALL implement the states IDLE, COLLECT, CONVERT, LOAD and ERROR.
REQ-016 SHALL define digit order: H tens, H ones, M tens, M ones, S tens, S ones.
REQ-017 SHALL assert digit_ready only in IDLE and COLLECT; a handshake occurs when digit_valid and digit_ready are both high.
REQ-018 SHALL validate each digit at handshake against these limits:
- H tens: at most 2.
- H ones: at most 9, or at most 3 when H tens is 2.
- M tens: at most 5.
- M ones: at most 9.
- S tens: at most 5.
- S ones: at most 9.
- Any value from 10 to 15: invalid.
REQ-019 SHALL, on a valid handshake, store the digit, increment digit_idx and enter or stay in COLLECT.
REQ-020 SHALL, on an invalid handshake, go to ERROR next cycle and not store the digit.
REQ-021 SHALL, after the sixth valid digit at cycle N:
- compute binary value = tens*10 + ones for each field in CONVERT at N+1;
- pulse set_load high at N+2 only, in LOAD;
- return to IDLE at N+3 with digit_idx = 0.
REQ-022 SHALL update set_hr, set_min and set_sec only in the set_load cycle, and hold them until the next set_load.
REQ-023 SHALL count idle cycles in COLLECT, clearing the count on each handshake; when the count reaches TIMEOUT_CYCLES, go to ERROR.
REQ-024 SHALL, in ERROR, pulse entry_err for exactly one cycle, then go to IDLE, clear digit_idx and discard the stored digits.
REQ-025 SHALL, when cancel is high in COLLECT or IDLE, go to IDLE next cycle, clear digit_idx, and assert neither set_load nor entry_err.
REQ-026 SHALL give cancel priority when cancel and a handshake occur in the same cycle; the digit is discarded.
REQ-027 SHALL ignore cancel in CONVERT, LOAD and ERROR.
REQ-028 SHALL never assert set_load and entry_err in the same cycle.
REQ-029 SHALL ignore digit_valid while digit_ready is low; no buffering.

Reset
REQ-030 SHALL, while rst_n is low, immediately force the following regardless of clk:
- state = IDLE;
- digit_idx = 0, timeout counter = 0;
- set_hr, set_min, set_sec = 0;
- set_load, entry_err, busy = 0;
- digit_ready = 1.
REQ-031 SHALL, when rst_n is asserted mid-entry, discard the partial entry with no strobe after release.
REQ-032 SHALL resume normal operation on the first rising clk edge after rst_n goes high.

Verification
REQ-033 SHALL cover: digits 2,3,5,9,5,9 back-to-back -> set_load pulses 2 cycles after the last digit; set_hr=23, set_min=59, set_sec=59.
REQ-034 SHALL cover: digits 2,4 -> entry_err pulses one cycle after the "4"; digit_idx returns to 0; set_* unchanged.
REQ-035 SHALL cover: digits 1,2,3 then idle with TIMEOUT_CYCLES=16 -> entry_err after 16 idle cycles; no set_load.
REQ-036 SHALL cover: digits 0,7 then cancel asserted together with digit 3 -> IDLE, digit_idx=0, no strobes; a following entry 0,0,0,0,0,1 loads set_sec=1.
REQ-037 SHALL cover: rst_n pulsed low after four digits -> outputs at reset values immediately; no strobe after release.
REQ-038 SHALL cover: digit_in=10 as the first digit -> entry_err; digit_ready low for the one-cycle ERROR state.
